// File: rtl/rng_pkg.sv
// rng_pkg: shared types for the rng range generator and its arbiter.
// The cfg struct is the {incr, cnt, base} word carried on every cfg channel.
package rng_pkg;

    localparam int W_INCR_D  = 16;
    localparam int W_CNT_D   = 16;
    localparam int W_START_D = 16;

    typedef struct packed {
        logic [W_INCR_D-1:0]  incr;
        logic [W_CNT_D-1:0]   cnt;
        logic [W_START_D-1:0] base;
    } rng_cfg_t;

    function automatic int w_id(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rng_arb_if.sv
// dti: valid/ready/data channel used for cfg words and generated samples.
// The producer owns valid and data, the consumer owns ready.
interface dti #(
    parameter int W = 1
);

    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);

endinterface

// File: rtl/rng_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; the first set, non-excluded
// request at or after start_i (with wrap) wins.
module rr_pick
    import rng_pkg::*;
#(
    parameter int N = 4,
    parameter int W = w_id(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    input  logic [N-1:0] excl_i,
    output logic [W-1:0] idx_o,
    output logic         hit_o
);

    logic [N-1:0] cand;
    int           j;

    assign cand = req_i & ~excl_i;

    // Walk offsets from far to near so the nearest candidate is written last.
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (cand[j]) begin
                idx_o = W'(j);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_arb.sv
// rng_arb: round-robin owner of one shared rng; the grant is held until the
// owner's whole range has been produced, and each sample is tagged with its id.
module rng_arb
    import rng_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W_INCR  = 16,
    parameter int W_CNT   = 16,
    parameter int W_START = 16,
    parameter int W_DATA  = 16,
    parameter int W_ID    = w_id(N_REQ)
) (
    input  logic            clk,
    input  logic            rst,
    dti.consumer            req [N_REQ],
    dti.producer            rng_cfg,
    dti.consumer            rng_dout,
    dti.producer            dout,
    output logic [W_ID-1:0] grant_id,
    output logic            busy
);

    localparam int W_CFG = W_INCR + W_CNT + W_START;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state_q;
    logic [W_ID-1:0]  grant_q;
    logic [W_ID-1:0]  last_q;
    logic [W_ID-1:0]  start;
    logic [W_ID-1:0]  win;
    logic             hit;
    logic             lock;
    logic             cfg_v;
    logic             xfer;
    logic [N_REQ-1:0] req_v;
    logic [N_REQ-1:0] excl;
    logic [W_CFG-1:0] req_d [N_REQ];
    logic [W_DATA:0]  smp;

    assign lock = (state_q == LOCK);

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign req_v[i]     = req[i].valid;
        assign req_d[i]     = req[i].data;
        assign req[i].ready = lock && (grant_q == W_ID'(i)) && rng_cfg.ready;
    end

    assign cfg_v         = lock & req_v[grant_q];
    assign rng_cfg.valid = cfg_v;
    assign rng_cfg.data  = req_d[grant_q];
    assign xfer          = cfg_v & rng_cfg.ready;

    // last_q equals the owner while locked, so one start serves both searches.
    assign start = (last_q == W_ID'(N_REQ - 1)) ? '0 : last_q + 1'b1;
    assign excl  = lock ? (N_REQ'(1) << grant_q) : '0;

    rr_pick #(
        .N (N_REQ),
        .W (W_ID)
    ) u_pick (
        .req_i   (req_v),
        .start_i (start),
        .excl_i  (excl),
        .idx_o   (win),
        .hit_o   (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= W_ID'(N_REQ - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_q <= LOCK;
                        grant_q <= win;
                        last_q  <= win;
                    end
                end
                LOCK: begin
                    if (xfer) begin
                        if (hit) begin
                            grant_q <= win;
                            last_q  <= win;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign grant_id = grant_q;
    assign busy     = lock;

    // Sample path is a wire; reset blanks it while the rng is being flushed.
    assign smp            = rng_dout.data;
    assign dout.valid     = rng_dout.valid & rst;
    assign rng_dout.ready = dout.ready & rst;
    assign dout.data      = {grant_q, smp};

`ifndef SYNTHESIS
    logic stall;
    assign stall = cfg_v & ~rng_cfg.ready;

    a_owner_hold: assert property (
        @(posedge clk) disable iff (!rst) stall |=> cfg_v
    ) else $warning("rng_arb: owner %0d dropped cfg valid before handshake", grant_q);
`endif

endmodule

// File: tb/tb_rng_arb.sv
// tb_rng_arb: scoreboard bench for rng_arb with a behavioural rng
// that emits base + k*incr for k in 0..cnt-1, eot on the last sample.
module tb_rng_arb;
    import rng_pkg::*;

    localparam int N  = 4;
    localparam int WC = 48;
    localparam int WD = 16;
    localparam int WI = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dti #(WC)         req_if [N] ();
    dti #(WC)         cfg_if ();
    dti #(WD + 1)     rd_if ();
    dti #(WI + 1 + WD) dout_if ();

    logic [WI-1:0] grant_id;
    logic          busy;

    rng_arb #(.N_REQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req_if),
        .rng_cfg  (cfg_if),
        .rng_dout (rd_if),
        .dout     (dout_if),
        .grant_id (grant_id),
        .busy     (busy)
    );

    logic [N-1:0] rv = '0;
    logic [N-1:0] nv = '0;
    logic [N-1:0] hs = '0;
    logic [N-1:0] rr;
    rng_cfg_t     cd [N];
    rng_cfg_t     nd [N];
    logic         out_rdy  = 1'b1;
    logic         rand_rdy = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign req_if[i].valid = rv[i];
        assign req_if[i].data  = cd[i];
        assign rr[i]           = req_if[i].ready;
    end
    assign dout_if.ready = out_rdy;

    // Behavioural stand-in for the shared rng instance.
    rng_cfg_t    mcfg;
    logic [15:0] k_q;
    logic        lst;
    assign mcfg         = cfg_if.data;
    assign lst          = (k_q == mcfg.cnt - 16'd1);
    assign rd_if.valid  = cfg_if.valid;
    assign rd_if.data   = {lst, 16'(mcfg.base + k_q * mcfg.incr)};
    assign cfg_if.ready = cfg_if.valid & rd_if.ready & lst;

    always @(posedge clk or negedge rst) begin
        if (!rst) k_q <= '0;
        else if (rd_if.valid && rd_if.ready) k_q <= lst ? '0 : k_q + 16'd1;
    end

    logic [WI+WD:0] sb [$];
    logic [WI+WD:0] exp_s;
    int checks   = 0;
    int failures = 0;

    always @(negedge clk) begin
        if (rst && dout_if.valid && dout_if.ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h exp=none", dout_if.data);
            end else begin
                exp_s = sb.pop_front();
                if (dout_if.data !== exp_s) begin
                    failures++;
                    $display("FAIL sb_sample got=%h exp=%h", dout_if.data, exp_s);
                end
            end
        end
    end

    function automatic rng_cfg_t mk(input int incr, input int cnt, input int base);
        rng_cfg_t c;
        c.incr = 16'(incr);
        c.cnt  = 16'(cnt);
        c.base = 16'(base);
        return c;
    endfunction

    task automatic push_range(input int id, input rng_cfg_t c);
        for (int k = 0; k < int'(c.cnt); k++) begin
            sb.push_back({2'(id), (k == int'(c.cnt) - 1), 16'(c.base + 16'(k) * c.incr)});
        end
    endtask

    task automatic load(input int i, input rng_cfg_t c);
        rv[i] = 1'b1;
        cd[i] = c;
    endtask

    task automatic step();
        @(negedge clk);
        hs = rv & rr;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (nv[i]) begin
                    cd[i] = nd[i];
                    nv[i] = 1'b0;
                end else begin
                    rv[i] = 1'b0;
                end
            end
        end
        if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        rv       = '0;
        nv       = '0;
        out_rdy  = 1'b1;
        rand_rdy = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((busy || rv != '0) && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        out_rdy = 1'b1;
        load(1, mk(1, 2, 0));
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({grant_id, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_state grant=%0d busy=%0b exp 0/0", grant_id, busy);
        end
        checks++;
        if ({cfg_if.valid, dout_if.valid, rd_if.ready, rr} !== 7'b0) begin
            failures++;
            $display("FAIL reset_hs cfg_v=%0b dout_v=%0b rd_rdy=%0b rr=%b exp all 0",
                     cfg_if.valid, dout_if.valid, rd_if.ready, rr);
        end
        rv = '0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        sb.push_back({2'd2, 1'b0, 16'd10});
        sb.push_back({2'd2, 1'b0, 16'd11});
        sb.push_back({2'd2, 1'b0, 16'd12});
        sb.push_back({2'd2, 1'b1, 16'd13});
        load(2, mk(1, 4, 10));
        step();
        checks++;
        if (grant_id !== 2'd2 || busy !== 1'b1 || cfg_if.valid !== 1'b1) begin
            failures++;
            $display("FAIL single_grant grant=%0d busy=%0b cfg_v=%0b exp 2/1/1",
                     grant_id, busy, cfg_if.valid);
        end
        for (int n = 0; n < 20 && !hs[2]; n++) step();
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL single_release grant=%0d busy=%0b exp 0/0", grant_id, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL single_drain left=%0d exp 0", sb.size());
        end
    endtask

    task automatic test_all_four();
        int n = 0;
        do_reset();
        push_range(0, mk(1, 2, 100));
        push_range(1, mk(2, 3, 200));
        push_range(2, mk(1, 2, 300));
        push_range(3, mk(5, 3, 400));
        push_range(0, mk(1, 2, 500));
        load(0, mk(1, 2, 100));
        load(1, mk(2, 3, 200));
        load(2, mk(1, 2, 300));
        load(3, mk(5, 3, 400));
        nv[0] = 1'b1;
        nd[0] = mk(1, 2, 500);
        step();
        checks++;
        if (grant_id !== 2'd0) begin
            failures++;
            $display("FAIL all4_first grant=%0d exp 0", grant_id);
        end
        while (busy && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL all4_cycles got=%0d exp 12", n);
        end
        checks++;
        if (sb.size() != 0 || rv != '0) begin
            failures++;
            $display("FAIL all4_drain left=%0d rv=%b exp 0/0", sb.size(), rv);
        end
    endtask

    task automatic test_regrant();
        do_reset();
        push_range(1, mk(1, 2, 20));
        push_range(1, mk(1, 3, 30));
        load(1, mk(1, 2, 20));
        nv[1] = 1'b1;
        nd[1] = mk(1, 3, 30);
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL regrant_idle grant=%0d busy=%0b exp 0/0", grant_id, busy);
        end
        step();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            failures++;
            $display("FAIL regrant_again grant=%0d busy=%0b exp 1/1", grant_id, busy);
        end
        drain(20);
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL regrant_drain busy=%0b left=%0d exp 0/0", busy, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        push_range(3, mk(3, 6, 50));
        load(3, mk(3, 6, 50));
        rand_rdy = 1'b1;
        step();
        while (busy && n < 200) begin
            checks++;
            if (grant_id !== 2'd3) begin
                failures++;
                $display("FAIL bp_grant grant=%0d exp 3", grant_id);
            end
            step();
            n++;
        end
        rand_rdy = 1'b0;
        out_rdy  = 1'b1;
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_drain busy=%0b left=%0d exp 0/0", busy, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_range(0, mk(1, 5, 100));
        load(0, mk(1, 5, 100));
        step();
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({cfg_if.valid, dout_if.valid, rd_if.ready, rr, busy} !== 8'b0) begin
            failures++;
            $display("FAIL midrst_hs cfg_v=%0b dout_v=%0b rd_rdy=%0b rr=%b busy=%0b exp all 0",
                     cfg_if.valid, dout_if.valid, rd_if.ready, rr, busy);
        end
        checks++;
        if (grant_id !== 2'd0) begin
            failures++;
            $display("FAIL midrst_grant grant=%0d exp 0", grant_id);
        end
        sb.delete();
        load(2, mk(2, 2, 40));
        push_range(0, mk(1, 5, 100));
        push_range(2, mk(2, 2, 40));
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        checks++;
        if (grant_id !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_regrant grant=%0d busy=%0b exp 0/1", grant_id, busy);
        end
        drain(40);
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL midrst_drain busy=%0b left=%0d exp 0/0", busy, sb.size());
        end
    endtask

    task automatic test_protocol();
        do_reset();
        out_rdy = 1'b0;
        load(0, mk(1, 3, 7));
        step();
        step();
        rv[0] = 1'b0;
        #1;
        checks++;
        if (cfg_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL proto_cfgv got=%0b exp 0", cfg_if.valid);
        end
        step();
        step();
        checks++;
        if (grant_id !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL proto_keep grant=%0d busy=%0b exp 0/1", grant_id, busy);
        end
        rv[0]   = 1'b1;
        out_rdy = 1'b1;
        push_range(0, mk(1, 3, 7));
        drain(20);
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL proto_drain busy=%0b left=%0d exp 0/0", busy, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_regrant();
        test_backpressure();
        test_mid_reset();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "tb_rng_arb: time limit");
    end

endmodule
